sqrt_dispatch: RTL and testbench
================================

Name: sqrt_dispatch

Overview:
- Upstream feeder and downstream collector for the iterative square-root engine (8-bit operand, start/ack handshake, root held on R while ack is high).
- Accepts operands on a valid/ready stream and issues each one to the engine with a one-cycle start pulse.
- Waits for a fresh ack, then checks the returned root and computes the remainder.
- Presents root/remainder/error on a valid/ready output stream with a one-entry output buffer.

Parameters:
- W, 8, operand width; matches engine operand width.
- RW, W/2+1, root and remainder field width.
- TIMEOUT, 2047, max cycles spent in WAIT_DROP plus WAIT_ACK before the operation is abandoned.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand available.
- in_a  in  W  operand.
- in_ready  out  1  operand accepted when in_valid&&in_ready.
- eng_a  out  W  operand to engine; stable from ISSUE until the next accept.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_ack  in  1  engine done (level; stays high until the engine accepts the next start).
- eng_r  in  W  engine root; valid while eng_ack=1.
- res_valid  out  1  output buffer full.
- res_root  out  RW  checked root.
- res_rem  out  RW  in_a - root*root.
- res_err  out  1  root failed check or timeout.
- res_ready  in  1  consumer takes result when res_valid&&res_ready.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; in_ready=0; eng_start=0; eng_a=0; res_valid=0; res_root=0; res_rem=0; res_err=0; timeout counter=0. Reset mid-operation abandons it silently; no result is produced.
- States: IDLE, ISSUE, WAIT_DROP, WAIT_ACK.
- IDLE: in_ready=1. On in_valid: latch in_a into eng_a and the operand register, go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; counter cleared; go to WAIT_DROP.
- WAIT_DROP: ignore eng_ack while it is high, because it is stale from the previous operation or from before reset. When eng_ack=0, go to WAIT_ACK. Counter increments each cycle.
- WAIT_ACK: when eng_ack=1 and the output buffer is empty, or is being emptied this cycle (res_ready=1):
  - load res_* from the checker;
  - set res_valid=1;
  - go to IDLE.
- If eng_ack=1 but the buffer stays full, remain in WAIT_ACK. The engine holds R/ack, and the counter is frozen while stalled.
- Timeout: counter reaches TIMEOUT in WAIT_DROP or WAIT_ACK with the buffer free. Load res_root=0, res_rem=0, res_err=1, set res_valid=1, go to IDLE. If the buffer is full, wait for it to free, then apply the same load.
- in_ready=1 only in IDLE. Operand acceptance while res_valid=1 is allowed (overlap of one compute with one held result).
- Output: res_valid clears on res_valid&&res_ready unless reloaded the same cycle. A simultaneous drain and load leaves res_valid=1 with the new data.
- Check (combinational on eng_r and operand A):
  - sq = r*r, 2W bits; nx = (r+1)*(r+1), 2W+1 bits.
  - ok = (sq<=A) && (nx>A) && (r < 2^(RW-1)).
  - ok: res_root=r, res_rem=A-sq truncated to RW, res_err=0.
  - not ok: res_root=r[RW-1:0], res_rem=0, res_err=1.
- Latency: accept to ISSUE is 1 cycle; res_valid rises the cycle after the qualifying eng_ack sample.

Decomposition:
- Package sqrt_pkg: state encoding (IDLE=0, ISSUE=1, WAIT_DROP=2, WAIT_ACK=3), default W/RW/TIMEOUT constants.
- One sub-module: sqrt_check (combinational; inputs A, r; outputs root, rem, err). Reused by the bench scoreboard.

Test Plan:
- in_a=49 with a behavioural engine acking after 40 cycles, res_ready=1 -> res_root=7, res_rem=0, res_err=0; exactly one eng_start pulse.
- in_a=50, then 255, then 0 back-to-back -> (7,1,0), (15,30,0), (0,0,0), in order, one start per operand.
- Engine ack already high at start (stale from prior op), drops 1 cycle after start, rises 30 cycles later with r=5 for A=30 -> result issued only after the rise: (5,5,0).
- Engine returns r=8 for A=49 -> res_err=1, res_rem=0, res_root=8.
- Engine never acks, TIMEOUT=100 -> res_valid at cycle 101 after ISSUE with res_err=1, root=0; next operand proceeds normally.
- res_ready=0 for 500 cycles with results 7 (A=49) held and A=100 in flight -> second result waits in WAIT_ACK; after res_ready=1: 7 then 10, no loss. Rst_n pulsed low during WAIT_ACK -> all outputs 0, state IDLE, no result emitted.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared encodings and default sizing for the square-root dispatch block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sqrt_pkg;

    localparam int W_DEF       = 8;
    localparam int RW_DEF      = W_DEF / 2 + 1;
    localparam int TIMEOUT_DEF = 2047;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DROP = 2'd2,
        WAIT_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/sqrt_check.sv
// Verifies an engine root against its operand and derives the remainder.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module sqrt_check
    import sqrt_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int RW = W / 2 + 1
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  r,
    output logic [RW-1:0] root,
    output logic [RW-1:0] rem,
    output logic          err
);

    logic [W:0]     r1;
    logic [2*W-1:0] sq;
    logic [2*W:0]   nx;
    logic           ok;

    // r is the root iff r^2 <= a < (r+1)^2 and it fits the result field.
    always_comb begin
        r1   = {1'b0, r} + {{W{1'b0}}, 1'b1};
        sq   = {{W{1'b0}}, r} * {{W{1'b0}}, r};
        nx   = {{W{1'b0}}, r1} * {{W{1'b0}}, r1};
        ok   = (sq <= {{W{1'b0}}, a}) &&
               (nx > {{(W+1){1'b0}}, a}) &&
               ((r >> (RW-1)) == '0);
        root = r[RW-1:0];
        // Low bits of a - r^2 are the low bits of the difference of low bits.
        rem  = ok ? (a[RW-1:0] - sq[RW-1:0]) : '0;
        err  = !ok;
    end

endmodule

// File: rtl/sqrt_dispatch.sv
// Feeds operands to the iterative sqrt engine and collects checked results.
// Latency: accept->start 1 cycle; result valid 1 cycle after the qualifying ack.
// Backpressure: in_ready only in IDLE; one-entry result buffer stalls WAIT_ACK when full.
module sqrt_dispatch
    import sqrt_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int RW      = W / 2 + 1,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_a,
    output logic          in_ready,
    output logic [W-1:0]  eng_a,
    output logic          eng_start,
    input  logic          eng_ack,
    input  logic [W-1:0]  eng_r,
    output logic          res_valid,
    output logic [RW-1:0] res_root,
    output logic [RW-1:0] res_rem,
    output logic          res_err,
    input  logic          res_ready
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  chk_root;
    logic [RW-1:0]  chk_rem;
    logic           chk_err;
    logic           drain;
    logic           buf_free;
    logic           cnt_hit;

    // eng_a doubles as the operand register: it is held until the next accept.
    sqrt_check #(.W(W), .RW(RW)) u_check (
        .a    (eng_a),
        .r    (eng_r),
        .root (chk_root),
        .rem  (chk_rem),
        .err  (chk_err)
    );

    assign drain    = res_valid && res_ready;
    assign buf_free = !res_valid || res_ready;
    // The last permitted wait cycle; result then lands TIMEOUT+1 cycles after ISSUE.
    assign cnt_hit  = (cnt == CNT_LAST);

    // Dispatch FSM with registered handshake outputs and the result buffer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            res_valid <= 1'b0;
            res_root  <= '0;
            res_rem   <= '0;
            res_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            eng_start <= 1'b0;
            // A load later in this block overrides the drain.
            if (drain) begin
                res_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        eng_a     <= in_a;
                        in_ready  <= 1'b0;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    // A high ack here is left over from an earlier operation.
                    if (cnt_hit) begin
                        if (buf_free) begin
                            res_valid <= 1'b1;
                            res_root  <= '0;
                            res_rem   <= '0;
                            res_err   <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (!eng_ack) begin
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    // A genuine ack wins over a timeout; while stalled the engine holds r.
                    if (eng_ack) begin
                        if (buf_free) begin
                            res_valid <= 1'b1;
                            res_root  <= chk_root;
                            res_rem   <= chk_rem;
                            res_err   <= chk_err;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (cnt_hit) begin
                        if (buf_free) begin
                            res_valid <= 1'b1;
                            res_root  <= '0;
                            res_rem   <= '0;
                            res_err   <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Randomized and directed bench for sqrt_dispatch with a behavioural engine and scoreboard.
// Latency: n/a.
// Backpressure: res_ready driven constant or random.
module tb_sqrt_dispatch;

    localparam int W  = 8;
    localparam int RW = W / 2 + 1;
    localparam int TO = 100;

    typedef struct {
        int root;
        int rem;
        int err;
    } res_t;

    // kind: 0 = acks with root, 1 = never acks (timeout expected), 2 = never acks, no result expected
    typedef struct {
        int kind;
        int drop;
        int lat;
        int force_r;
    } ecfg_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic          in_ready;
    logic [W-1:0]  eng_a;
    logic          eng_start;
    logic          eng_ack = 1'b0;
    logic [W-1:0]  eng_r = '0;
    logic          res_valid;
    logic [RW-1:0] res_root;
    logic [RW-1:0] res_rem;
    logic          res_err;
    logic          res_ready;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    nstart = 0;
    int    start_cyc = 0;
    int    load_cyc = 0;
    int    ack_cyc = 0;
    int    rdy_mode = 1;
    res_t  exp_q[$];
    res_t  got_q[$];
    ecfg_t cfg_q[$];

    sqrt_dispatch #(.W(W), .RW(RW), .TIMEOUT(TO)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_ready  (in_ready),
        .eng_a     (eng_a),
        .eng_start (eng_start),
        .eng_ack   (eng_ack),
        .eng_r     (eng_r),
        .res_valid (res_valid),
        .res_root  (res_root),
        .res_rem   (res_rem),
        .res_err   (res_err),
        .res_ready (res_ready)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int isqrt(input int a);
        int s = 0;
        while ((s + 1) * (s + 1) <= a) s++;
        return s;
    endfunction

    // What the dispatcher must report for operand a given engine answer r.
    function automatic res_t model(input int a, input int r);
        res_t m;
        if (r * r <= a && (r + 1) * (r + 1) > a && r < (1 << (RW - 1))) begin
            m.root = r;
            m.rem  = (a - r * r) % (1 << RW);
            m.err  = 0;
        end else begin
            m.root = r % (1 << RW);
            m.rem  = 0;
            m.err  = 1;
        end
        return m;
    endfunction

    function automatic ecfg_t mk(input int kind, input int drop, input int lat, input int force_r);
        ecfg_t c;
        c.kind = kind; c.drop = drop; c.lat = lat; c.force_r = force_r;
        return c;
    endfunction

    // res_ready driver: 0 = hold off, 1 = always ready, 2 = random
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (rdy_mode == 2) res_ready = ($urandom_range(0, 3) != 0);
            else               res_ready = (rdy_mode == 1);
        end
    end

    // Behavioural engine: drops ack after a start, raises it with a root later.
    initial begin
        ecfg_t c;
        int    a;
        int    r;
        res_t  t;
        forever begin
            @(posedge Clk); #1;
            if (eng_start) begin
                a = int'(eng_a);
                if (cfg_q.size() > 0) c = cfg_q.pop_front();
                else                  c = mk(0, 1, 4, -1);
                if (c.kind == 1) begin
                    t.root = 0; t.rem = 0; t.err = 1;
                    exp_q.push_back(t);
                end
                repeat (c.drop) begin @(posedge Clk); #1; end
                eng_ack = 1'b0;
                if (c.kind == 0) begin
                    repeat (c.lat) begin @(posedge Clk); #1; end
                    r = (c.force_r >= 0) ? c.force_r : isqrt(a);
                    eng_r   = W'(r);
                    eng_ack = 1'b1;
                    ack_cyc = cyc;
                    exp_q.push_back(model(a, r));
                end
            end
        end
    end

    // Output compare: every cycle while out of reset.
    initial begin
        bit   pv, pr, ps;
        int   proot, prem, perr;
        res_t e;
        res_t g;
        pv = 0; pr = 0; ps = 0; proot = 0; prem = 0; perr = 0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                pv = 0; pr = 0; ps = 0;
            end else begin
                if (eng_start) begin
                    nstart++;
                    start_cyc = cyc;
                    chk("start_single_cycle", int'(ps), 0);
                end
                if (pv && !pr) begin
                    chk("hold_valid", int'(res_valid), 1);
                    chk("hold_root", int'(res_root), proot);
                    chk("hold_rem", int'(res_rem), prem);
                    chk("hold_err", int'(res_err), perr);
                end
                if (res_valid && (!pv || pr)) load_cyc = cyc;
                if (res_valid && res_ready) begin
                    g.root = int'(res_root); g.rem = int'(res_rem); g.err = int'(res_err);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_root", g.root, e.root);
                        chk("res_rem", g.rem, e.rem);
                        chk("res_err", g.err, e.err);
                    end
                    got_q.push_back(g);
                end
                pv = res_valid; pr = res_ready; ps = eng_start;
                proot = int'(res_root); prem = int'(res_rem); perr = int'(res_err);
            end
        end
    end

    task automatic send(input int a, input ecfg_t c);
        int n = 0;
        cfg_q.push_back(c);
        in_a = W'(a);
        in_valid = 1'b1;
        forever begin
            @(negedge Clk);
            if (in_ready) break;
            n++;
            if (n > 5000) begin
                chk("send_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge Clk);
            if (in_ready && !res_valid && exp_q.size() == 0 && cfg_q.size() == 0) break;
            n++;
            if (n > 4000) begin
                chk("wait_idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic chk_got(input string name, input int idx, input int root, input int rem, input int err);
        if (idx >= got_q.size()) begin
            chk({name, "_missing"}, got_q.size(), idx + 1);
        end else begin
            chk({name, "_root"}, got_q[idx].root, root);
            chk({name, "_rem"}, got_q[idx].rem, rem);
            chk({name, "_err"}, got_q[idx].err, err);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_eng_start"}, int'(eng_start), 0);
        chk({tag, "_eng_a"}, int'(eng_a), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_root"}, int'(res_root), 0);
        chk({tag, "_res_rem"}, int'(res_rem), 0);
        chk({tag, "_res_err"}, int'(res_err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        int   g0;
        int   s0;
        int   a;
        int   drop;
        int   lat;
        int   fr;

        // Model pinned by hand-computed values.
        m = model(49, 7);  chk("model_49_7_root", m.root, 7);  chk("model_49_7_rem", m.rem, 0);  chk("model_49_7_err", m.err, 0);
        m = model(255, 15); chk("model_255_rem", m.rem, 30);   chk("model_255_err", m.err, 0);
        m = model(49, 8);  chk("model_49_8_root", m.root, 8);  chk("model_49_8_rem", m.rem, 0);  chk("model_49_8_err", m.err, 1);

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk_zero_outputs("reset");
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Single operand, slow engine.
        g0 = got_q.size(); s0 = nstart;
        send(49, mk(0, 1, 40, -1));
        wait_idle();
        chk_got("a49", g0, 7, 0, 0);
        chk("a49_starts", nstart - s0, 1);

        // Back-to-back operands.
        g0 = got_q.size(); s0 = nstart;
        send(50, mk(0, 1, 3, -1));
        send(255, mk(0, 0, 5, -1));
        send(0, mk(0, 2, 2, -1));
        wait_idle();
        chk_got("b2b_50", g0, 7, 1, 0);
        chk_got("b2b_255", g0 + 1, 15, 30, 0);
        chk_got("b2b_0", g0 + 2, 0, 0, 0);
        chk("b2b_starts", nstart - s0, 3);

        // Stale ack still high at start; result must follow the fresh rise.
        chk("stale_ack_high_before", int'(eng_ack), 1);
        g0 = got_q.size();
        send(30, mk(0, 1, 30, -1));
        wait_idle();
        chk_got("stale_30", g0, 5, 5, 0);
        chk("stale_load_after_rise", load_cyc - ack_cyc, 1);

        // Wrong root from engine.
        g0 = got_q.size();
        send(49, mk(0, 1, 6, 8));
        wait_idle();
        chk_got("bad_root", g0, 8, 0, 1);

        // Engine never acks.
        g0 = got_q.size();
        send(77, mk(1, 1, 0, -1));
        wait_idle();
        chk_got("timeout", g0, 0, 0, 1);
        chk("timeout_latency", load_cyc - start_cyc, TO + 1);
        send(16, mk(0, 1, 7, -1));
        wait_idle();
        chk_got("after_timeout", g0 + 1, 4, 0, 0);

        // Held result plus one stalled compute; stall outlasts the timeout.
        g0 = got_q.size();
        rdy_mode = 0;
        @(posedge Clk); #1;
        send(49, mk(0, 1, 5, -1));
        send(100, mk(0, 1, 20, -1));
        repeat (500) @(posedge Clk);
        #1;
        chk("stall_res_valid", int'(res_valid), 1);
        chk("stall_res_root", int'(res_root), 7);
        chk("stall_not_idle", int'(in_ready), 0);
        chk("stall_none_taken", got_q.size() - g0, 0);
        rdy_mode = 1;
        wait_idle();
        chk_got("stall_first", g0, 7, 0, 0);
        chk_got("stall_second", g0 + 1, 10, 0, 0);

        // Randomized operands, engine timing, wrong roots and consumer stalls.
        rdy_mode = 2;
        g0 = got_q.size();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1;
            a    = int'($urandom_range(0, 255));
            drop = int'($urandom_range(0, 3));
            lat  = (drop == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(1, 15));
            fr   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1;
            send(a, mk(0, drop, lat, fr));
        end
        wait_idle();
        chk("random_count", got_q.size() - g0, 40);
        rdy_mode = 1;

        // Reset while waiting for the engine: silent abandon.
        g0 = got_q.size();
        send(81, mk(2, 1, 0, -1));
        repeat (10) @(posedge Clk);
        #1;
        chk("pre_reset_busy", int'(in_ready), 0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (3) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (30) @(posedge Clk);
        #1;
        chk("post_reset_no_result", got_q.size() - g0, 0);
        chk("post_reset_res_valid", int'(res_valid), 0);
        chk("post_reset_idle", int'(in_ready), 1);
        send(64, mk(0, 1, 9, -1));
        wait_idle();
        chk_got("post_reset_64", g0, 8, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
